// File: rtl/reg_file_reader.sv
// reg_file_reader
//   DEPTH x WIDTH register file with one write port, two registered read
//   ports (write-first bypass), and a dump engine that streams every register
//   out over valid/ready for debug/trace.
// Ports
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_we, i_waddr, i_wdata            write port (writes to reg 0 discarded)
//   i_re, i_raddr_a, i_raddr_b        read request, latency 1
//   o_rvalid, o_rdata_a, o_rdata_b    read results (data holds when idle)
//   i_dump_start                      start a full dump (accepted in IDLE only)
//   o_dump_valid, i_dump_ready        dump beat handshake
//   o_dump_addr, o_dump_data          current dump beat
//   o_dump_done                       1-cycle pulse after last beat accepted
module reg_file_reader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic              o_rvalid,
  output logic [WIDTH-1:0]  o_rdata_a,
  output logic [WIDTH-1:0]  o_rdata_b,
  input  logic              i_dump_start,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic [WIDTH-1:0]  o_dump_data,
  output logic              o_dump_done
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic                        r_rvalid;
  logic [WIDTH-1:0]            r_rdata_a, r_rdata_b;
  state_t                      r_state, w_state_nxt;
  logic [ADDR_W-1:0]           r_dump_addr, w_addr_nxt;
  logic [WIDTH-1:0]            r_dump_data, w_data_nxt;
  logic                        r_dump_done, w_done_nxt;

  logic                        w_wr_ok;
  logic [WIDTH-1:0]            w_rd_a, w_rd_b;
  logic [ADDR_W-1:0]           w_dump_inc;
  logic [WIDTH-1:0]            w_dump_rd;
  logic                        w_dump_last;

  // Reg 0 is never written, so it stays 0 and needs no read-side masking.
  assign w_wr_ok = i_we && (i_waddr != '0);

  // Write-first bypass: a same-cycle write to the read address wins.
  assign w_rd_a = (w_wr_ok && (i_waddr == i_raddr_a)) ? i_wdata : r_mem[i_raddr_a];
  assign w_rd_b = (w_wr_ok && (i_waddr == i_raddr_b)) ? i_wdata : r_mem[i_raddr_b];

  // Next dump beat; w_dump_inc is only used when addr < DEPTH-1, so never 0.
  assign w_dump_inc  = r_dump_addr + 1'b1;
  assign w_dump_rd   = (w_wr_ok && (i_waddr == w_dump_inc)) ? i_wdata : r_mem[w_dump_inc];
  assign w_dump_last = (r_dump_addr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem <= '0;
    end else if (w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid  <= 1'b0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      r_rvalid <= i_re;
      if (i_re) begin
        r_rdata_a <= w_rd_a;
        r_rdata_b <= w_rd_b;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_dump_addr <= '0;
      r_dump_data <= '0;
      r_dump_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dump_addr <= w_addr_nxt;
      r_dump_data <= w_data_nxt;
      r_dump_done <= w_done_nxt;
    end
  end

  // Beat registers only move on start or handshake, so a stalled beat stays
  // stable even if its register is overwritten meanwhile.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_dump_addr;
    w_data_nxt  = r_dump_data;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_dump_start) begin
          w_state_nxt = S_RUN;
          w_addr_nxt  = '0;
          w_data_nxt  = '0;
        end
      end
      S_RUN: begin
        if (i_dump_ready) begin
          if (w_dump_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_addr_nxt = w_dump_inc;
            w_data_nxt = w_dump_rd;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_rvalid     = r_rvalid;
  assign o_rdata_a    = r_rdata_a;
  assign o_rdata_b    = r_rdata_b;
  assign o_dump_valid = (r_state == S_RUN);
  assign o_dump_addr  = r_dump_addr;
  assign o_dump_data  = r_dump_data;
  assign o_dump_done  = r_dump_done;

endmodule

// File: tb/tb_reg_file_reader.sv
module tb_reg_file_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re, dump_start, dump_ready;
  logic [3:0]  waddr, raddr_a, raddr_b;
  logic [31:0] wdata;
  logic        rvalid, dump_valid, dump_done;
  logic [31:0] rdata_a, rdata_b, dump_data;
  logic [3:0]  dump_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_reader #(.WIDTH(32), .DEPTH(16), .ADDR_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_re(re), .i_raddr_a(raddr_a), .i_raddr_b(raddr_b),
    .o_rvalid(rvalid), .o_rdata_a(rdata_a), .o_rdata_b(rdata_b),
    .i_dump_start(dump_start), .o_dump_valid(dump_valid), .i_dump_ready(dump_ready),
    .o_dump_addr(dump_addr), .o_dump_data(dump_data), .o_dump_done(dump_done)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [3:0]  ra, rb;
    logic        ev;
    logic [31:0] ea, eb;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we = 0; waddr = 0; wdata = 0; re = 0; raddr_a = 0; raddr_b = 0;
    dump_start = 0; dump_ready = 1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rvalid"}, {31'b0, rvalid}, 0);
    chk({nm, "_rdata_a"}, rdata_a, 0);
    chk({nm, "_rdata_b"}, rdata_b, 0);
    chk({nm, "_dvalid"}, {31'b0, dump_valid}, 0);
    chk({nm, "_daddr"}, {28'b0, dump_addr}, 0);
    chk({nm, "_ddata"}, dump_data, 0);
    chk({nm, "_ddone"}, {31'b0, dump_done}, 0);
  endtask

  // Reference model state for the random phase
  logic [31:0] m_mem[16];
  logic        m_rv, m_act, m_done;
  logic [31:0] m_ra, m_rb, m_dd;
  int          m_idx;

  initial begin
    idle_in();
    rst_n = 0;
    #1;
    chk_all_zero("reset0");
    #12 rst_n = 1;
    cyc();

    // Write / read / bypass table
    tbl[0] = '{1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd5, 4'd0, 1'b1, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 4'd7, 32'h11,       1'b0, 4'd0, 4'd0, 1'b0, 32'hDEADBEEF, 32'h0};
    tbl[3] = '{1'b1, 4'd7, 32'h22,       1'b1, 4'd7, 4'd7, 1'b1, 32'h22, 32'h22};
    tbl[4] = '{1'b1, 4'd0, 32'hFF,       1'b1, 4'd0, 4'd0, 1'b1, 32'h0, 32'h0};
    tbl[5] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd7, 4'd5, 1'b1, 32'h22, 32'hDEADBEEF};
    tbl[6] = '{1'b1, 4'd3, 32'h33,       1'b1, 4'd3, 4'd2, 1'b1, 32'h33, 32'h0};
    tbl[7] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd0, 1'b0, 32'h33, 32'h0};
    tbl[8] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd15, 4'd3, 1'b1, 32'h0, 32'h33};
    for (int i = 0; i < 9; i++) begin
      we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
      re = tbl[i].re; raddr_a = tbl[i].ra; raddr_b = tbl[i].rb;
      cyc();
      chk($sformatf("tbl%0d_rvalid", i), {31'b0, rvalid}, {31'b0, tbl[i].ev});
      chk($sformatf("tbl%0d_rdata_a", i), rdata_a, tbl[i].ea);
      chk($sformatf("tbl%0d_rdata_b", i), rdata_b, tbl[i].eb);
    end
    idle_in();

    // Full dump with ready tied high, start pulsed mid-dump
    for (int i = 1; i < 16; i++) begin
      we = 1; waddr = 4'(i); wdata = 32'(i * 256);
      cyc();
    end
    we = 0; dump_start = 1; dump_ready = 1;
    cyc();
    dump_start = 0;
    for (int k = 0; k < 16; k++) begin
      chk("dump_valid", {31'b0, dump_valid}, 1);
      chk("dump_addr", {28'b0, dump_addr}, 32'(k));
      chk("dump_data", dump_data, 32'(k * 256));
      chk("dump_done_low", {31'b0, dump_done}, 0);
      dump_start = (k == 5);
      cyc();
    end
    chk("dump_end_valid", {31'b0, dump_valid}, 0);
    chk("dump_end_done", {31'b0, dump_done}, 1);
    cyc();
    chk("dump_done_pulse", {31'b0, dump_done}, 0);
    chk("dump_idle_valid", {31'b0, dump_valid}, 0);

    // Backpressure on addr 4 while reg 4 is overwritten
    dump_start = 1;
    cyc();
    dump_start = 0;
    for (int k = 0; k < 4; k++) cyc();
    chk("bp_addr4", {28'b0, dump_addr}, 4);
    chk("bp_data4", dump_data, 32'h400);
    dump_ready = 0; we = 1; waddr = 4; wdata = 32'hAB;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_hold_valid", {31'b0, dump_valid}, 1);
      chk("bp_hold_addr", {28'b0, dump_addr}, 4);
      chk("bp_hold_data", dump_data, 32'h400);
    end
    dump_ready = 1; waddr = 5; wdata = 32'hCD;
    cyc();
    chk("bp_next_addr", {28'b0, dump_addr}, 5);
    chk("bp_next_data", dump_data, 32'hCD);
    we = 0;
    for (int k = 0; k < 10; k++) cyc();
    chk("bp_last_addr", {28'b0, dump_addr}, 15);
    chk("bp_last_data", dump_data, 32'hF00);
    cyc();
    chk("bp_done", {31'b0, dump_done}, 1);
    // Start in the done cycle restarts at 0
    dump_start = 1;
    cyc();
    dump_start = 0;
    chk("restart_valid", {31'b0, dump_valid}, 1);
    chk("restart_addr", {28'b0, dump_addr}, 0);
    chk("restart_done", {31'b0, dump_done}, 0);

    // Run to addr 9 with a read in flight, then reset asynchronously
    re = 1; raddr_a = 4; raddr_b = 5;
    cyc();
    re = 0;
    chk("rd_a_after_wr", rdata_a, 32'hAB);
    chk("rd_b_after_wr", rdata_b, 32'hCD);
    for (int k = 0; k < 8; k++) cyc();
    chk("pre_rst_addr", {28'b0, dump_addr}, 9);
    #2 rst_n = 0;
    #1;
    chk_all_zero("async_rst");
    #3 rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("post_rst_nodone", {31'b0, dump_done}, 0);
      chk("post_rst_novalid", {31'b0, dump_valid}, 0);
    end
    re = 1; raddr_a = 5; raddr_b = 15;
    cyc();
    re = 0;
    chk("post_rst_rd_a", rdata_a, 0);
    chk("post_rst_rd_b", rdata_b, 0);
    chk("post_rst_rvalid", {31'b0, rvalid}, 1);
    dump_start = 1;
    cyc();
    dump_start = 0;
    chk("post_rst_dump_valid", {31'b0, dump_valid}, 1);
    chk("post_rst_dump_addr", {28'b0, dump_addr}, 0);

    // Random phase against a behavioural model, from a clean reset
    #2 rst_n = 0;
    #3 rst_n = 1;
    idle_in();
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    m_rv = 0; m_ra = 0; m_rb = 0; m_act = 0; m_done = 0; m_dd = 0; m_idx = 0;
    for (int c = 0; c < 1500; c++) begin
      we = ($urandom_range(1, 0) == 1);
      waddr = 4'($urandom_range(15, 0));
      wdata = $urandom;
      re = ($urandom_range(1, 0) == 1);
      raddr_a = (c % 7 == 0) ? waddr : 4'($urandom_range(15, 0));
      raddr_b = 4'($urandom_range(15, 0));
      dump_start = ($urandom_range(19, 0) == 0);
      dump_ready = ($urandom_range(9, 0) < 7);

      // Read ports: write-first on the same register, reg 0 always zero
      m_rv = re;
      if (re) begin
        m_ra = (raddr_a == 0) ? 0 : ((we && waddr == raddr_a) ? wdata : m_mem[raddr_a]);
        m_rb = (raddr_b == 0) ? 0 : ((we && waddr == raddr_b) ? wdata : m_mem[raddr_b]);
      end
      // Dump stream: registers 0..15 in order, one per accepted beat
      m_done = 0;
      if (!m_act) begin
        if (dump_start) begin
          m_act = 1; m_idx = 0; m_dd = 0;
        end
      end else if (dump_ready) begin
        if (m_idx == 15) begin
          m_act = 0; m_done = 1;
        end else begin
          m_idx = m_idx + 1;
          m_dd = (we && waddr == 4'(m_idx)) ? wdata : m_mem[m_idx];
        end
      end
      if (we && waddr != 0) m_mem[waddr] = wdata;

      cyc();
      chk("rnd_rvalid", {31'b0, rvalid}, {31'b0, m_rv});
      chk("rnd_rdata_a", rdata_a, m_ra);
      chk("rnd_rdata_b", rdata_b, m_rb);
      chk("rnd_dvalid", {31'b0, dump_valid}, {31'b0, m_act});
      chk("rnd_daddr", {28'b0, dump_addr}, 32'(m_idx));
      chk("rnd_ddata", dump_data, m_dd);
      chk("rnd_ddone", {31'b0, dump_done}, {31'b0, m_done});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
